// File: rtl/out_bcd.sv
// Binary-to-BCD converter for the CPU output port: detects a change of the
// output word and converts it with a shift-add-3 engine, one bit per clock.
//
// state | meaning
// IDLE  | waiting for the input word to differ from the last captured value
// SHIFT | double-dabble iteration in progress, one input bit per clock
module out_bcd #(
    parameter int DATA_WIDTH = 16,
    parameter int DIGITS     = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   in,
    output logic [4*DIGITS-1:0]     bcd,
    output logic                    busy,
    output logic                    done
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int BCD_W = 4 * DIGITS;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   last;
    logic [DATA_WIDTH-1:0]   bin;
    logic [BCD_W-1:0]        work;
    logic [CNT_W-1:0]        cnt;

    logic [BCD_W-1:0]        work_corr;
    logic [BCD_W-1:0]        work_nxt;
    logic [DATA_WIDTH-1:0]   bin_nxt;

    // Each digit >= 5 gets +3 before the shift so it carries correctly into the next digit.
    always_comb begin
        work_corr = work;
        for (int k = 0; k < DIGITS; k++) begin
            if (work[4*k +: 4] >= 4'd5) begin
                work_corr[4*k +: 4] = work[4*k +: 4] + 4'd3;
            end
        end
        work_nxt = {work_corr[BCD_W-2:0], bin[DATA_WIDTH-1]};
        bin_nxt  = {bin[DATA_WIDTH-2:0], 1'b0};
    end

    assign busy = (state == SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            bcd   <= '0;
            work  <= '0;
            bin   <= '0;
            last  <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in != last) begin
                        bin   <= in;
                        last  <= in;
                        work  <= '0;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    work <= work_nxt;
                    bin  <= bin_nxt;
                    cnt  <= cnt + CNT_W'(1);
                    // Final iteration: publish the fully shifted result directly.
                    if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
                        bcd   <= work_nxt;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_out_bcd.sv
// Self-checking bench for out_bcd: stimulus pushes expected results into a
// queue, a negedge monitor pops and compares on every done pulse.
module tb_out_bcd;

    localparam int DW = 16;
    localparam int ND = 5;
    localparam int LAT = DW + 1;

    logic            clk;
    logic            rst;
    logic [DW-1:0]   in;
    logic [4*ND-1:0] bcd;
    logic            busy;
    logic            done;

    out_bcd #(.DATA_WIDTH(DW), .DIGITS(ND)) dut (
        .clk  (clk),
        .rst  (rst),
        .in   (in),
        .bcd  (bcd),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4*ND-1:0] val;
        int              cyc;
    } exp_t;

    exp_t            q[$];
    int              n_cmp = 0;
    int              n_err = 0;
    int              cyc = 0;
    int              done_cnt = 0;
    logic            rst_q = 1'b1;
    logic            done_prev = 1'b0;
    logic [4*ND-1:0] prev_bcd = '0;
    int              model_last = 0;

    function automatic logic [4*ND-1:0] ref_bcd(input int v);
        logic [4*ND-1:0] r;
        int              x;
        r = '0;
        x = v;
        for (int k = 0; k < ND; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc   = cyc + 1;
        rst_q = rst;
    end

    // Monitor: compares each done pulse against the head of the scoreboard.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (done === 1'b1) begin
                done_cnt++;
                chk("done_twice", {31'd0, done_prev}, 32'd0);
                chk("done_busy_overlap", {31'd0, busy}, 32'd0);
                chk("unexpected_done", {31'd0, q.size() != 0}, 32'd1);
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("bcd_result", 32'(bcd), 32'(e.val));
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                end
            end else if (bcd !== prev_bcd && rst_q !== 1'b1) begin
                chk("bcd_changed_without_done", 32'(bcd), 32'(prev_bcd));
            end
            done_prev = done;
            prev_bcd  = bcd;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge where the next posedge is E0 of a conversion of v.
    task automatic expect_conv(input int v);
        exp_t e;
        e.val = ref_bcd(v);
        e.cyc = cyc + LAT;
        q.push_back(e);
        model_last = v;
    endtask

    task automatic drive(input int v);
        in = DW'(v);
        if (v != model_last) expect_conv(v);
    endtask

    task automatic drain();
        int budget;
        budget = 200;
        while (q.size() != 0 && budget > 0) begin
            tick(1);
            budget--;
        end
        chk("drain_timeout", 32'(q.size()), 32'd0);
        tick(1);
    endtask

    initial begin
        int d0;
        int v;
        rst = 1'b1;
        in  = 16'hFFFF;
        tick(2);
        rst = 1'b0;
        in  = 16'd0;
        chk("reset_bcd", 32'(bcd), 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        tick(40);
        chk("reset_no_done", 32'(done_cnt), 32'd0);

        drive(1234);
        tick(1);
        chk("basic_busy_after_e0", {31'd0, busy}, 32'd1);
        drain();
        chk("basic_busy_low", {31'd0, busy}, 32'd0);
        d0 = done_cnt;
        tick(30);
        chk("hold_no_done", 32'(done_cnt), 32'(d0));

        drive(65535);
        drain();
        drive(0);
        drain();
        drive(9);
        drain();

        // Input change mid-conversion: the second value starts right after done.
        drive(500);
        tick(5);
        in = 16'd42;
        begin
            exp_t e;
            e.val = ref_bcd(42);
            e.cyc = cyc - 5 + 2 * LAT;
            q.push_back(e);
            model_last = 42;
        end
        drain();

        // Reset after 8 shift edges; conversion restarts since last is cleared.
        in = 16'd777;
        tick(9);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("midreset_bcd", 32'(bcd), 32'd0);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_done", {31'd0, done}, 32'd0);
        model_last = 0;
        drive(777);
        drain();

        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 7))
                0: v = 0;
                1: v = 65535;
                2: v = model_last;
                3: v = 9999 + $urandom_range(0, 1);
                default: v = int'($urandom_range(0, 65535));
            endcase
            drive(v);
            tick(18 + $urandom_range(0, 3));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/out_bcd.md
# out_bcd

Sequential binary-to-BCD converter sitting directly downstream of the CPU's `out` port. It watches the 16-bit output word and detects every change. Each new value is converted to packed BCD digits with an iterative shift-add-3 (double-dabble) engine, one bit per clock. The result feeds the board's seven-segment digit drivers.

## Interface

Parameters:
- `DATA_WIDTH`, 16: width of the binary input; matches the CPU data width.
- `DIGITS`, 5: number of BCD digits produced. Must satisfy 10^DIGITS > 2^DATA_WIDTH − 1; this is not checked in hardware.

Ports:
- `clk`: input, 1 bit. Single clock, rising edge.
- `rst`: input, 1 bit. Reset is synchronous and active-high.
- `in`: input, `DATA_WIDTH` bits. Binary word, connected to the CPU `out`.
- `bcd`: output, `4*DIGITS` bits. Packed BCD result. Digit k (10^k) occupies bits [4k+3:4k]; the least significant digit is in the LSBs. Registered.
- `busy`: output, 1 bit. High while a conversion is in progress (state SHIFT). Registered-state decode.
- `done`: output, 1 bit. One-cycle pulse, high in the cycle in which `bcd` first shows a new result. Registered.

## Operation

Internal registers:
- `last`: the last captured input, `DATA_WIDTH` bits.
- `bin`: the shift source, `DATA_WIDTH` bits.
- `work`: the BCD accumulator, `4*DIGITS` bits.
- `cnt`: the iteration counter, clog2(DATA_WIDTH+1) bits.
- `state`: one of IDLE or SHIFT.

Reset (`rst`=1 at a rising edge) sets:
- state = IDLE;
- `bcd`, `work`, `bin`, `last`, `cnt` = 0;
- `done` = 0.
- Reset has priority over all other activity, including a conversion in progress. A partial result is never written to `bcd`.
- Because `last` resets to 0, an input of 0 after reset triggers no conversion, and `bcd` = 0 is already correct.

IDLE state:
- `busy` = 0 and `done` = 0 (unless this is the pulse cycle described below).
- If `in` != `last`:
  - capture `in` into both `bin` and `last`;
  - clear `work` and `cnt`;
  - go to SHIFT.
- If `in` == `last`: stay in IDLE; `bcd` holds its value.

SHIFT state, on each edge:
- Correct every digit of `work`: if the digit is ≥ 5, add 3 to it (4-bit, no carry out of the digit).
- Then shift the concatenation {corrected `work`, `bin`} left by 1; the MSB of `bin` enters bit 0 of `work`.
- Increment `cnt`.
- On the edge where `cnt` == DATA_WIDTH−1 (the final iteration):
  - write the shifted-and-corrected value straight into `bcd`;
  - set `done` = 1;
  - go to IDLE.
- `in` is ignored while in SHIFT. Changes are not queued.

Returning to IDLE:
- `in` is compared against `last` again. If it differs, a new conversion starts.
- This means only the value present at a sampling point in IDLE is converted; intermediate values seen during SHIFT are dropped.

Arithmetic:
- Unsigned only.
- Digits above the value's magnitude read 0.

## Timing

- Let E0 be the first rising edge in IDLE at which `in` != `last`.
- Edges E1..E(DATA_WIDTH) perform the shifts.
- After E(DATA_WIDTH):
  - `bcd` holds the new result;
  - `done` = 1 for exactly one cycle;
  - `busy` = 0.
- Latency is DATA_WIDTH+1 edges from E0 (17 with defaults).
- `busy` is high from after E0 until after E(DATA_WIDTH), i.e. DATA_WIDTH cycles.
- Back-to-back conversions:
  - the edge after E(DATA_WIDTH) is an IDLE edge and may itself act as E0 for the next conversion;
  - the minimum spacing between `done` pulses is DATA_WIDTH+1 cycles.
- `bcd` changes only on `done` edges or on reset.
- `done` pulse behaviour:
  - `done` never stays high for two consecutive cycles;
  - `done` and `busy` are never high in the same cycle, except when a new conversion starts on the edge after E(DATA_WIDTH). In that case `done` deasserts on that same edge anyway.
- Reset held during SHIFT: the edge with `rst`=1 returns the block to IDLE with all outputs 0. No `done` pulse occurs.

## Test plan

- **Reset values:** assert `rst` for 2 cycles with `in`=16'hFFFF; release with `in`=0 → `bcd`=20'h00000, `busy`=0, and no `done` pulse for 40 cycles.
- **Basic conversion:** set `in`=16'd1234 → `busy` rises after E0; after 17 edges `bcd`=20'h01234 and `done` is high for one cycle. Then hold `in` for 30 cycles → no further `done`.
- **Full scale:** `in`=16'd65535 → `bcd`=20'h65535. Then `in`=16'd0 → `bcd`=20'h00000 with a fresh `done`. Then `in`=16'd9 → `bcd`=20'h00009.
- **Input change mid-conversion:**
  - `in`=16'd500; 5 cycles later `in`=16'd42 → first `done` with `bcd`=20'h00500;
  - the next edge starts a new conversion → second `done` 17 cycles later with `bcd`=20'h00042.
- **Reset mid-operation:** start with `in`=16'd777; assert `rst` for 1 cycle after 8 shift edges → `bcd`=0, `busy`=0, no `done`. With `in` still 777 after release → a conversion restarts and ends with `bcd`=20'h00777.
- **Randomised check:** 200 random `in` values, each held for ≥18 cycles → after each `done`, `bcd` equals a reference decimal conversion.
